serial_adder: RTL and testbench

- Bit-serial adder for the datapath; the add-direction counterpart of the combinational subtractor.
- Latches two unsigned WIDTH-bit operands on a start pulse.
- Adds one bit per clock, LSB first, through a single full adder and a carry flop.
- Reports sum and carry-out with a one-cycle done pulse. Used where area matters more than latency.

---
 rtl/serial_adder.sv | 109 ++++++++++
 tb/tb_serial_adder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder, one full adder plus carry flop
// Optional signed-overflow output ovf enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;

    // carry holds the running carry flop, so it is also the final carry-out
    assign fa_sum  = a_q[0] ^ b_q[0] ^ carry;
    assign fa_cout = (a_q[0] & b_q[0]) | (a_q[0] & carry) | (b_q[0] & carry);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            cnt   <= '0;
            sum   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= in1;
                        b_q   <= in2;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (cnt == CNT_END) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        sum   <= {fa_sum, sum[WIDTH-1:1]};
                        a_q   <= a_q >> 1;
                        b_q   <= b_q >> 1;
                        carry <= fa_cout;
                        cnt   <= cnt + CW'(1);
`ifdef SERIAL_ADDER_OVF_EN
                        // carry into the MSB is the flop value before this edge
                        if (cnt == CNT_LAST) ovf <= carry ^ fa_cout;
`endif
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q   <= in1;
                        b_q   <= in2;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and random checks of serial_adder against an arithmetic model
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] in1 = '0;
    logic [3:0] in2 = '0;
    logic [3:0] sum;
    logic       carry;
    logic       busy;
    logic       done;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .in1  (in1),
        .in2  (in2),
        .sum  (sum),
        .carry(carry),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf  (ovf),
`endif
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(posedge clk);
    endtask

    // Returns on the negedge where done is seen; edges counts from the start edge as 1.
    task automatic wait_done(input int hold, output int edges);
        int h;
        h = hold;
        edges = 1;
        forever begin
            @(negedge clk);
            if (done === 1'b1 || edges >= 20) break;
            if (h > 0) begin
                start = 1'b1;
                in1   = 4'($urandom);
                in2   = 4'($urandom);
                h--;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic check_result(input string tag, input logic [3:0] a, input logic [3:0] b,
                                input int edges);
        int total;
        int sa;
        int sb;
        total = int'(a) + int'(b);
        chk({tag, " latency"}, edges, 6);
        chk({tag, " done"}, done, 1);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " sum"}, sum, total % 16);
        chk({tag, " carry"}, carry, (total >= 16) ? 1 : 0);
`ifdef SERIAL_ADDER_OVF_EN
        sa = a[3] ? int'(a) - 16 : int'(a);
        sb = b[3] ? int'(b) - 16 : int'(b);
        chk({tag, " ovf"}, ovf, (sa + sb > 7 || sa + sb < -8) ? 1 : 0);
`else
        sa = 0;
        sb = 0;
`endif
    endtask

    task automatic full_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input int hold);
        int edges;
        int total;
        total = int'(a) + int'(b);
        issue(a, b);
        wait_done(hold, edges);
        check_result(tag, a, b, edges);
        start = 1'b0;
        @(negedge clk);
        chk({tag, " pulse"}, done, 0);
        chk({tag, " hold sum"}, sum, total % 16);
        chk({tag, " hold carry"}, carry, (total >= 16) ? 1 : 0);
    endtask

    initial begin
        int edges;
        logic [3:0] ra;
        logic [3:0] rb;

        #2;
        chk("rst sum", sum, 0);
        chk("rst carry", carry, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        full_op("basic", 4'b0100, 4'b0011, 0);
        full_op("carry", 4'b1111, 4'b1000, 0);
        full_op("swap", 4'b1000, 4'b1111, 0);
        full_op("held start", 4'b0101, 4'b0101, 3);
`ifdef SERIAL_ADDER_OVF_EN
        full_op("ovf pos", 4'b0111, 4'b0001, 0);
        full_op("ovf wrap", 4'b1111, 4'b0001, 0);
`endif

        // back-to-back: start asserted in the done cycle
        issue(4'd9, 4'd12);
        wait_done(0, edges);
        check_result("b2b first", 4'd9, 4'd12, edges);
        in1   = 4'd1;
        in2   = 4'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b no gap busy", busy, 1);
        chk("b2b no gap done", done, 0);
        wait_done(0, edges);
        check_result("b2b second", 4'd1, 4'd2, edges);
        start = 1'b0;
        @(negedge clk);

        // asynchronous reset during the second RUN cycle
        issue(4'd13, 4'd7);
        @(posedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid rst sum", sum, 0);
        chk("mid rst carry", carry, 0);
        chk("mid rst busy", busy, 0);
        chk("mid rst done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        full_op("after rst", 4'd6, 4'd11, 0);

        for (int i = 0; i < 10; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            full_op($sformatf("rand%0d", i), ra, rb, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
